// File: rtl/checkers_pkg.sv
// Shared square encoding and board geometry for the checkers LED display path.
// Each board row is one 32-bit word holding eight 4-bit square codes.
package checkers_pkg;

  localparam int NUM_ROWS   = 8;
  localparam int NUM_COLS   = 8;
  localparam int HILITE_BIT = 3;

  localparam logic [2:0] SQ_EMPTY    = 3'd0;
  localparam logic [2:0] SQ_RED_MAN  = 3'd1;
  localparam logic [2:0] SQ_RED_KING = 3'd2;
  localparam logic [2:0] SQ_BLK_MAN  = 3'd3;
  localparam logic [2:0] SQ_BLK_KING = 3'd4;

  typedef logic [31:0]         row_word_t;
  typedef logic [NUM_ROWS-1:0] row_mask_t;

  // Active-low one-cold row strobe for the given row index.
  function automatic row_mask_t row_select_n(input logic [2:0] idx);
    return ~(row_mask_t'(1) << idx);
  endfunction

endpackage

// File: rtl/checkers_led_scan_if.sv
// Pin-side bundle of the LED scanner: board row words in, matrix drive out.
// The master is the scanner; the slave is whatever feeds the rows and watches the pins.
interface checkers_led_scan_if;
  import checkers_pkg::*;

  row_word_t row0_in;
  row_word_t row1_in;
  row_word_t row2_in;
  row_word_t row3_in;
  row_word_t row4_in;
  row_word_t row5_in;
  row_word_t row6_in;
  row_word_t row7_in;

  row_mask_t            led_row_n;
  logic [NUM_COLS-1:0]  led_red;
  logic [NUM_COLS-1:0]  led_grn;
  logic                 frame_tick;

  modport master (
    input  row0_in, row1_in, row2_in, row3_in,
    input  row4_in, row5_in, row6_in, row7_in,
    output led_row_n, led_red, led_grn, frame_tick
  );

  modport slave (
    output row0_in, row1_in, row2_in, row3_in,
    output row4_in, row5_in, row6_in, row7_in,
    input  led_row_n, led_red, led_grn, frame_tick
  );

endinterface

// File: rtl/checkers_square_decode.sv
// Maps one square code nibble to red/green column drive for the current cycle.
// Men follow pwm_on for half brightness; highlighted squares go dark on blink.
module checkers_square_decode
  import checkers_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       pwm_on,
  input  logic       blink_phase,
  output logic       red,
  output logic       grn
);

  logic hilite;

  assign hilite = nibble[HILITE_BIT];

  always_comb begin
    red = 1'b0;
    grn = 1'b0;
    case (nibble[2:0])
      SQ_RED_MAN:  red = pwm_on;
      SQ_RED_KING: red = 1'b1;
      SQ_BLK_MAN:  grn = pwm_on;
      SQ_BLK_KING: grn = 1'b1;
      // Empty and unused codes: amber marker when highlighted.
      default: begin
        red = hilite;
        grn = hilite;
      end
    endcase
    if (hilite && blink_phase) begin
      red = 1'b0;
      grn = 1'b0;
    end
  end

endmodule

// File: rtl/checkers_led_scan.sv
// Row-multiplexed driver for the 8x8 bicolour checkers matrix: per-frame snapshot,
// dwell/row/frame counters, anti-ghost blanking and registered pin outputs.
module checkers_led_scan
  import checkers_pkg::*;
#(
  parameter int SCAN_DIV     = 6250,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  checkers_led_scan_if.master   bus
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  row_word_t row_in   [NUM_ROWS];
  row_word_t snap_reg [NUM_ROWS];
  row_word_t row_word;

  logic [DW-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic [2:0]    row_idx_reg, row_idx_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          blink_phase_reg, blink_phase_next;

  logic [NUM_ROWS-1:0] led_row_n_reg, led_row_n_next;
  logic [NUM_COLS-1:0] led_red_reg, led_red_next;
  logic [NUM_COLS-1:0] led_grn_reg, led_grn_next;
  logic                frame_tick_reg, frame_tick_next;

  logic dwell_wrap;
  logic frame_wrap;
  logic snap_take;
  logic blank;
  logic pwm_on;

  logic [NUM_COLS-1:0] col_red;
  logic [NUM_COLS-1:0] col_grn;

  assign row_in[0] = bus.row0_in;
  assign row_in[1] = bus.row1_in;
  assign row_in[2] = bus.row2_in;
  assign row_in[3] = bus.row3_in;
  assign row_in[4] = bus.row4_in;
  assign row_in[5] = bus.row5_in;
  assign row_in[6] = bus.row6_in;
  assign row_in[7] = bus.row7_in;

  assign dwell_wrap = (dwell_cnt_reg == DWELL_LAST);
  assign frame_wrap = dwell_wrap && (row_idx_reg == 3'(NUM_ROWS - 1));
  assign snap_take  = (row_idx_reg == 3'd0) && (dwell_cnt_reg == '0);
  assign blank      = (dwell_cnt_reg < BLANK_END);
  assign pwm_on     = ~dwell_cnt_reg[0];
  assign row_word   = snap_reg[row_idx_reg];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
      checkers_square_decode u_decode (
        .nibble      (row_word[4*gi +: 4]),
        .pwm_on      (pwm_on),
        .blink_phase (blink_phase_reg),
        .red         (col_red[gi]),
        .grn         (col_grn[gi])
      );
    end
  endgenerate

  // Blink state only moves on the frame wrap, so it never changes inside a row.
  always_comb begin
    dwell_cnt_next   = dwell_wrap ? '0 : dwell_cnt_reg + DW'(1);
    row_idx_next     = dwell_wrap ? row_idx_reg + 3'd1 : row_idx_reg;
    frame_cnt_next   = frame_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (frame_wrap) begin
      if (frame_cnt_reg == FRAME_LAST) begin
        frame_cnt_next   = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + FW'(1);
      end
    end
  end

  always_comb begin
    led_row_n_next  = blank ? '1 : row_select_n(row_idx_reg);
    led_red_next    = blank ? '0 : col_red;
    led_grn_next    = blank ? '0 : col_grn;
    frame_tick_next = snap_take;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt_reg   <= '0;
      row_idx_reg     <= '0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      led_row_n_reg   <= '1;
      led_red_reg     <= '0;
      led_grn_reg     <= '0;
      frame_tick_reg  <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        snap_reg[i] <= '0;
      end
    end else begin
      dwell_cnt_reg   <= dwell_cnt_next;
      row_idx_reg     <= row_idx_next;
      frame_cnt_reg   <= frame_cnt_next;
      blink_phase_reg <= blink_phase_next;
      led_row_n_reg   <= led_row_n_next;
      led_red_reg     <= led_red_next;
      led_grn_reg     <= led_grn_next;
      frame_tick_reg  <= frame_tick_next;
      if (snap_take) begin
        for (int i = 0; i < NUM_ROWS; i++) begin
          snap_reg[i] <= row_in[i];
        end
      end
    end
  end

  assign bus.led_row_n  = led_row_n_reg;
  assign bus.led_red    = led_red_reg;
  assign bus.led_grn    = led_grn_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_checkers_led_scan.sv
// Directed bench for checkers_led_scan with a short scan (8 cycles/row, 2 blank, 2-frame blink).
module tb_checkers_led_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = SD * 8;

  typedef struct {
    logic [7:0] fr;  // red at full duty
    logic [7:0] mr;  // red at half duty
    logic [7:0] fg;  // green at full duty
    logic [7:0] mg;  // green at half duty
    logic [7:0] hl;  // highlighted (blink) columns
  } row_exp_t;

  logic clk;
  logic reset_n;
  int   edges;
  int   tests_run;
  int   tests_failed;

  row_exp_t pend [8];
  row_exp_t show [8];

  checkers_led_scan_if bus ();

  checkers_led_scan #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_row(input int r, input logic [31:0] w, input logic [7:0] fr,
                          input logic [7:0] mr, input logic [7:0] fg, input logic [7:0] mg,
                          input logic [7:0] hl);
    pend[r] = '{fr: fr, mr: mr, fg: fg, mg: mg, hl: hl};
    case (r)
      0: bus.row0_in = w;
      1: bus.row1_in = w;
      2: bus.row2_in = w;
      3: bus.row3_in = w;
      4: bus.row4_in = w;
      5: bus.row5_in = w;
      6: bus.row6_in = w;
      default: bus.row7_in = w;
    endcase
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_row_n"}, 32'(bus.led_row_n), 32'hFF);
    check({tag, "_red"},   32'(bus.led_red),   32'h00);
    check({tag, "_grn"},   32'(bus.led_grn),   32'h00);
    check({tag, "_tick"},  32'(bus.frame_tick), 32'h0);
  endtask

  // Outputs seen at a negedge reflect the counter state n = edges-1.
  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      int n, row, d, frame;
      logic blink, blank;
      logic [7:0] e_rn, e_red, e_grn, dark;
      @(negedge clk);
      n = edges - 1;
      if (n % FRAME == 0) begin
        for (int r = 0; r < 8; r++) show[r] = pend[r];
      end
      row   = (n / SD) % 8;
      d     = n % SD;
      frame = n / FRAME;
      blink = ((frame / BF) % 2) == 1;
      blank = d < BC;
      dark  = blink ? show[row].hl : 8'h00;
      e_rn  = blank ? 8'hFF : ~(8'h01 << row);
      e_red = blank ? 8'h00 : ((show[row].fr | ((d % 2 == 0) ? show[row].mr : 8'h00)) & ~dark);
      e_grn = blank ? 8'h00 : ((show[row].fg | ((d % 2 == 0) ? show[row].mg : 8'h00)) & ~dark);
      check($sformatf("n%0d_row_n", n), 32'(bus.led_row_n), 32'(e_rn));
      check($sformatf("n%0d_red", n),   32'(bus.led_red),   32'(e_red));
      check($sformatf("n%0d_grn", n),   32'(bus.led_grn),   32'(e_grn));
      check($sformatf("n%0d_tick", n),  32'(bus.frame_tick), (n % FRAME == 0) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    for (int r = 0; r < 8; r++) begin
      load_row(r, 32'hDEAD_BEEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      show[r] = pend[r];
    end

    // Held in reset with garbage rows: pins stay blank.
    repeat (4) begin
      @(negedge clk);
      check_reset_pins("rst_hold");
    end

    for (int r = 0; r < 8; r++) load_row(r, 32'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    load_row(0, 32'h0000_0030, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00);  // black man col1
    load_row(3, 32'h0000_0002, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);  // red king col0
    load_row(5, 32'h0000_0A00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04);  // hilite red king col2
    load_row(7, 32'h7654_3218, 8'h05, 8'h02, 8'h11, 8'h08, 8'h01);  // mixed codes
    reset_n = 1'b1;

    // Into frame 1 (row 1), then change row 3: must stay hidden until frame 2.
    run(75);
    load_row(3, 32'h0000_0004, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);  // black king col0
    run(370);  // ends on row 7, dwell 4 of frame 6

    // Asynchronous reset mid-drive blanks the pins without a clock edge.
    #2 reset_n = 1'b0;
    #1 check_reset_pins("rst_async");
    for (int r = 0; r < 8; r++) load_row(r, 32'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    load_row(2, 32'h0000_0001, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);  // red man col0
    repeat (2) begin
      @(negedge clk);
      check_reset_pins("rst_mid");
    end
    reset_n = 1'b1;
    run(2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
